// File: rtl/sobel_pkg.sv
// Shared widths, pipeline latency and helpers for the 3x3 Sobel edge detector.
package sobel_pkg;

  localparam int SUM_W    = 10;
  localparam int MAG_W    = 11;
  localparam int PIPE_LAT = 4;

  function automatic logic [SUM_W-1:0] sobel_absdiff(input logic [SUM_W-1:0] a,
                                                     input logic [SUM_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register with async active-low clear, used to keep
// sync signals aligned with pipelined data.
module sync_delay_line #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/sobel_edge_detect_3x3.sv
// 4-stage Sobel |Gx|+|Gy| edge detector on a 3x3 window stream.
// Optional per-frame edge counter enabled by defining SOBEL_EDGE_COUNT_EN.
module sobel_edge_detect_3x3
  import sobel_pkg::*;
#(
  parameter logic [9:0] IMG_HDISP = 10'd640,
  parameter logic [9:0] IMG_VDISP = 10'd480,
  parameter int         CNT_W     = 21
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             matrix_frame_vsync,
  input  logic             matrix_frame_href,
  input  logic [7:0]       matrix_p11,
  input  logic [7:0]       matrix_p12,
  input  logic [7:0]       matrix_p13,
  input  logic [7:0]       matrix_p21,
  input  logic [7:0]       matrix_p22,
  input  logic [7:0]       matrix_p23,
  input  logic [7:0]       matrix_p31,
  input  logic [7:0]       matrix_p32,
  input  logic [7:0]       matrix_p33,
  input  logic [7:0]       Sobel_Threshold,
  output logic             post_frame_vsync,
  output logic             post_frame_href,
  output logic [7:0]       post_img_Gray,
  output logic             post_img_Bit,
  output logic [CNT_W-1:0] frame_edge_cnt
);

  localparam int unsigned PIX_TOTAL = 32'(IMG_HDISP) * 32'(IMG_VDISP);
  localparam int unsigned CNT_CAP   = 32'd1 << CNT_W;

  if (CNT_CAP <= PIX_TOTAL) begin : g_cnt_w_check
    $error("CNT_W too small for IMG_HDISP*IMG_VDISP");
  end

  function automatic logic [SUM_W-1:0] wsum(input logic [7:0] a,
                                            input logic [7:0] b,
                                            input logic [7:0] c);
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  logic [SUM_W-1:0] gx_p, gx_n, gy_p, gy_n;
  logic [SUM_W-1:0] abs_gx, abs_gy;
  logic [MAG_W-1:0] mag;
  logic [7:0]       thr;
  logic [1:0]       sync_d3;

  // The datapath runs every cycle; href only gates the final outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx_p   <= '0;
      gx_n   <= '0;
      gy_p   <= '0;
      gy_n   <= '0;
      abs_gx <= '0;
      abs_gy <= '0;
      mag    <= '0;
      thr    <= '0;
    end else begin
      gx_p   <= wsum(matrix_p13, matrix_p23, matrix_p33);
      gx_n   <= wsum(matrix_p11, matrix_p21, matrix_p31);
      gy_p   <= wsum(matrix_p31, matrix_p32, matrix_p33);
      gy_n   <= wsum(matrix_p11, matrix_p12, matrix_p13);
      abs_gx <= sobel_absdiff(gx_p, gx_n);
      abs_gy <= sobel_absdiff(gy_p, gy_n);
      mag    <= {1'b0, abs_gx} + {1'b0, abs_gy};
      thr    <= Sobel_Threshold;
    end
  end

  sync_delay_line #(
    .DEPTH (PIPE_LAT - 1),
    .WIDTH (2)
  ) u_sync_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({matrix_frame_vsync, matrix_frame_href}),
    .dout  (sync_d3)
  );

  // Last stage registers sync and data together so all outputs share latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_img_Gray    <= 8'd0;
      post_img_Bit     <= 1'b0;
    end else begin
      post_frame_vsync <= sync_d3[1];
      post_frame_href  <= sync_d3[0];
      post_img_Gray    <= sync_d3[0] ? ((mag > MAG_W'(255)) ? 8'hFF : mag[7:0]) : 8'd0;
      post_img_Bit     <= sync_d3[0] & (mag > {3'b000, thr});
    end
  end

`ifdef SOBEL_EDGE_COUNT_EN
  logic [CNT_W-1:0] run_cnt, run_next, edge_cnt;
  logic             vs_prev, edge_hit;

  always_comb begin
    edge_hit = post_frame_href & post_img_Bit;
    run_next = run_cnt;
    if (edge_hit && (run_cnt != '1)) run_next = run_cnt + CNT_W'(1);
  end

  // Frame end is the vsync fall; the edge seen in that cycle is included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt  <= '0;
      edge_cnt <= '0;
      vs_prev  <= 1'b0;
    end else begin
      vs_prev <= post_frame_vsync;
      if (vs_prev && !post_frame_vsync) begin
        edge_cnt <= run_next;
        run_cnt  <= '0;
      end else begin
        run_cnt  <= run_next;
      end
    end
  end

  assign frame_edge_cnt = edge_cnt;
`else
  assign frame_edge_cnt = '0;
`endif

endmodule

// File: tb/tb_sobel_edge_detect_3x3.sv
// Self-checking bench for sobel_edge_detect_3x3: directed windows with
// hand-computed results plus a per-cycle behavioural reference model.
module tb_sobel_edge_detect_3x3;

  localparam int CNT_W = 21;
  localparam int MAXC  = 4096;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             vsync = 1'b0;
  logic             href = 1'b0;
  logic [71:0]      win = '0;
  logic [7:0]       thr = 8'd0;
  logic             post_frame_vsync, post_frame_href, post_img_Bit;
  logic [7:0]       post_img_Gray;
  logic [CNT_W-1:0] frame_edge_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sobel_edge_detect_3x3 #(
    .IMG_HDISP (10'd640),
    .IMG_VDISP (10'd480),
    .CNT_W     (CNT_W)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .matrix_frame_vsync (vsync),
    .matrix_frame_href  (href),
    .matrix_p11         (win[71:64]),
    .matrix_p12         (win[63:56]),
    .matrix_p13         (win[55:48]),
    .matrix_p21         (win[47:40]),
    .matrix_p22         (win[39:32]),
    .matrix_p23         (win[31:24]),
    .matrix_p31         (win[23:16]),
    .matrix_p32         (win[15:8]),
    .matrix_p33         (win[7:0]),
    .Sobel_Threshold    (thr),
    .post_frame_vsync   (post_frame_vsync),
    .post_frame_href    (post_frame_href),
    .post_img_Gray      (post_img_Gray),
    .post_img_Bit       (post_img_Bit),
    .frame_edge_cnt     (frame_edge_cnt)
  );

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic int tap(input logic [71:0] w, input int r, input int c);
    return int'(w[71 - 8*((r-1)*3 + (c-1)) -: 8]);
  endfunction

  function automatic int sobelMag(input logic [71:0] w);
    int gx, gy;
    gx = (tap(w,1,3) + 2*tap(w,2,3) + tap(w,3,3)) - (tap(w,1,1) + 2*tap(w,2,1) + tap(w,3,1));
    gy = (tap(w,3,1) + 2*tap(w,3,2) + tap(w,3,3)) - (tap(w,1,1) + 2*tap(w,1,2) + tap(w,1,3));
    return ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
  endfunction

  // Inputs as seen at each rising edge, indexed by edge number.
  logic [71:0] recWin [MAXC];
  logic        recHref [MAXC];
  logic        recVs [MAXC];
  logic        recRstLow [MAXC];
  logic [7:0]  recThr [MAXC];
  int          edgeIdx = 0;

  always @(posedge clk) begin
    if (edgeIdx < MAXC) begin
      recWin[edgeIdx]    = win;
      recHref[edgeIdx]   = href;
      recVs[edgeIdx]     = vsync;
      recRstLow[edgeIdx] = !rst_n;
      recThr[edgeIdx]    = thr;
    end
    edgeIdx++;
  end

  int   expRun = 0, expFrame = 0;
  logic h1Vs = 1'b0, h2Vs = 1'b0, h1Inc = 1'b0;

  // Reference: output after edge c reflects the window taken at edge c-3 and
  // the threshold taken at edge c-1, unless a reset landed in between.
  always @(negedge clk) begin : compare
    int   c, k, m, eGray, nr, expFrameOut;
    logic zero, rstNow, eVs, eHref, eBit, fall;
    c      = edgeIdx - 1;
    rstNow = !rst_n || ((c >= 0) && (c < MAXC) && recRstLow[c]);
    zero   = (c < 3) || (c >= MAXC) || !rst_n;
    for (int j = 0; j < 4; j++)
      if ((c - j >= 0) && (c - j < MAXC) && recRstLow[c-j]) zero = 1'b1;
    eVs = 1'b0; eHref = 1'b0; eGray = 0; eBit = 1'b0;
    if (!zero) begin
      k     = c - 3;
      m     = sobelMag(recWin[k]);
      eHref = recHref[k];
      eVs   = recVs[k];
      eGray = eHref ? ((m > 255) ? 255 : m) : 0;
      eBit  = eHref && (m > int'(recThr[c-1]));
    end
    if (rstNow) begin
      expRun = 0; expFrame = 0; h1Vs = 1'b0; h2Vs = 1'b0; h1Inc = 1'b0;
    end else begin
      fall = h2Vs && !h1Vs;
      nr   = (h1Inc && expRun != (2**CNT_W - 1)) ? expRun + 1 : expRun;
      if (fall) begin
        expFrame = nr;
        expRun   = 0;
      end else begin
        expRun   = nr;
      end
    end
    h2Vs  = h1Vs;
    h1Vs  = eVs;
    h1Inc = eHref && eBit;
`ifdef SOBEL_EDGE_COUNT_EN
    expFrameOut = expFrame;
`else
    expFrameOut = 0;
`endif
    checkOutput("model_vsync", 32'(post_frame_vsync), 32'(eVs));
    checkOutput("model_href",  32'(post_frame_href),  32'(eHref));
    checkOutput("model_gray",  32'(post_img_Gray),    eGray);
    checkOutput("model_bit",   32'(post_img_Bit),     32'(eBit));
    checkOutput("model_edge_cnt", 32'(frame_edge_cnt), expFrameOut);
  end

  task automatic stepCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [71:0] w, input logic h, input logic v, input logic [7:0] t);
    win = w; href = h; vsync = v; thr = t;
    stepCycle();
  endtask

  task automatic runIdle(input int n);
    for (int i = 0; i < n; i++) applyStimulus('0, 1'b0, vsync, thr);
  endtask

  function automatic logic [71:0] randWin();
    logic [71:0] w;
    for (int i = 0; i < 9; i++) w[i*8 +: 8] = 8'($urandom_range(0, 255));
    return w;
  endfunction

  localparam logic [71:0] FLAT  = {9{8'd100}};
  localparam logic [71:0] VEDGE = {8'd0, 8'd128, 8'd255, 8'd0, 8'd128, 8'd255, 8'd0, 8'd128, 8'd255};
  localparam logic [71:0] W20   = {8'd0, 8'd0, 8'd10, 48'd0};

  int edgePos [7] = '{3, 17, 30, 41, 50, 66, 79};

  initial begin
    repeat (3) stepCycle();
    checkOutput("reset_href",  32'(post_frame_href),  0);
    checkOutput("reset_vsync", 32'(post_frame_vsync), 0);
    checkOutput("reset_gray",  32'(post_img_Gray),    0);
    checkOutput("reset_bit",   32'(post_img_Bit),     0);
    checkOutput("reset_cnt",   32'(frame_edge_cnt),   0);
    rst_n = 1'b1;
    runIdle(3);

    // Flat window: zero gradient, exactly 4 cycles of latency.
    applyStimulus(FLAT, 1'b1, 1'b1, 8'd0);
    applyStimulus('0, 1'b0, 1'b1, 8'd0);
    stepCycle();
    checkOutput("lat_href_early", 32'(post_frame_href), 0);
    stepCycle();
    checkOutput("lat_href", 32'(post_frame_href), 1);
    checkOutput("flat_gray", 32'(post_img_Gray), 0);
    checkOutput("flat_bit",  32'(post_img_Bit),  0);

    // Vertical edge saturates the gray output.
    applyStimulus(VEDGE, 1'b1, 1'b1, 8'd0);
    runIdle(3);
    checkOutput("vedge_gray", 32'(post_img_Gray), 255);
    checkOutput("vedge_bit",  32'(post_img_Bit),  1);

    // Threshold boundary around mag = 20.
    applyStimulus(W20, 1'b1, 1'b1, 8'd20);
    runIdle(3);
    checkOutput("thr20_gray", 32'(post_img_Gray), 20);
    checkOutput("thr20_bit",  32'(post_img_Bit),  0);
    applyStimulus(W20, 1'b1, 1'b1, 8'd19);
    runIdle(3);
    checkOutput("thr19_gray", 32'(post_img_Gray), 20);
    checkOutput("thr19_bit",  32'(post_img_Bit),  1);
    vsync = 1'b0;
    runIdle(6);

    // 16x5 random frame with blanking and a mid-line threshold change,
    // followed by a frame with zero line blanking.
    for (int f = 0; f < 2; f++) begin
      thr = 8'd150;
      vsync = 1'b1;
      runIdle(2);
      for (int y = 0; y < 5; y++) begin
        for (int x = 0; x < 16; x++)
          applyStimulus(randWin(), 1'b1, 1'b1, (y == 2 && x >= 8) ? 8'd220 : 8'd150);
        if (f == 0) runIdle(3);
      end
      vsync = 1'b0;
      runIdle(6);
    end

    // Reset asserted in the middle of a line.
    vsync = 1'b1;
    for (int i = 0; i < 6; i++) applyStimulus(randWin(), 1'b1, 1'b1, 8'd40);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_href", 32'(post_frame_href),  0);
    checkOutput("midrst_vs",   32'(post_frame_vsync), 0);
    checkOutput("midrst_gray", 32'(post_img_Gray),    0);
    checkOutput("midrst_bit",  32'(post_img_Bit),     0);
    stepCycle();
    stepCycle();
    rst_n = 1'b1;
    href  = 1'b0;
    runIdle(2);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(VEDGE, 1'b1, 1'b1, 8'd40);
      if (i == 2) checkOutput("postrst_href_early", 32'(post_frame_href), 0);
      if (i == 3) checkOutput("postrst_href", 32'(post_frame_href), 1);
    end
    vsync = 1'b0;
    runIdle(6);

    // Frame with exactly 7 strong edges, then a frame with none.
    for (int f = 0; f < 2; f++) begin
      vsync = 1'b1;
      runIdle(2);
      for (int p = 0; p < 80; p++) begin
        logic hit;
        hit = 1'b0;
        for (int e = 0; e < 7; e++) if (edgePos[e] == p && f == 0) hit = 1'b1;
        applyStimulus(hit ? VEDGE : FLAT, 1'b1, 1'b1, 8'd50);
        if (p % 16 == 15) runIdle(2);
      end
`ifdef SOBEL_EDGE_COUNT_EN
      if (f == 1) checkOutput("cnt_hold", 32'(frame_edge_cnt), 7);
`endif
      vsync = 1'b0;
      runIdle(8);
`ifdef SOBEL_EDGE_COUNT_EN
      checkOutput("cnt_frame", 32'(frame_edge_cnt), (f == 0) ? 7 : 0);
`else
      checkOutput("cnt_tied", 32'(frame_edge_cnt), 0);
`endif
    end

    runIdle(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
